// File: rtl/router_sync.sv
// router_sync: address latch and channel control for the 1x3 router.
//
// Captures the 2-bit destination address when the controller decodes a header,
// steers the controller's write request to the selected output FIFO, returns
// that FIFO's full flag, and flushes any channel whose data sits unread for
// TIMEOUT consecutive cycles.
//
// Ports:
//   clock            sole clock, rising edge
//   resetn           synchronous active-low reset
//   detect_add       latch data_in as the new destination address
//   data_in[1:0]     header address (0..2 valid, 3 = no channel)
//   write_enb_reg    controller write request for the current byte
//   read_enb_0/1/2   destination-side read strobes
//   empty_0/1/2      FIFO empty flags
//   full_0/1/2       FIFO full flags
//   write_enb[2:0]   one-hot FIFO write enable
//   fifo_full        full flag of the addressed FIFO
//   vld_out_0/1/2    channel holds data
//   soft_reset_0/1/2 one-cycle flush pulse after a read timeout
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  // Watchdogs count down from TIMEOUT-1; reaching zero on a stalled edge
  // means TIMEOUT consecutive stalled edges have been seen.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  logic [1:0] addr;
  logic [2:0] vld;
  logic [2:0] rd;
  logic [2:0] soft_reset;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr <= 2'b11;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

  always_comb begin
    fifo_full = 1'b0;
    case (addr)
      2'd0:    fifo_full = full_0;
      2'd1:    fifo_full = full_1;
      2'd2:    fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  for (genvar ch = 0; ch < 3; ch++) begin : g_wdog
    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = vld[ch] & ~rd[ch];

    always_ff @(posedge clock) begin
      if (!resetn) begin
        cnt            <= CNT_LOAD;
        soft_reset[ch] <= 1'b0;
      end else if (!stall) begin
        cnt            <= CNT_LOAD;
        soft_reset[ch] <= 1'b0;
      end else if (cnt == '0) begin
        // Reload so a persisting stall fires again TIMEOUT edges later.
        cnt            <= CNT_LOAD;
        soft_reset[ch] <= 1'b1;
      end else begin
        cnt            <= cnt - 1'b1;
        soft_reset[ch] <= 1'b0;
      end
    end
  end

  assign soft_reset_0 = soft_reset[0];
  assign soft_reset_1 = soft_reset[1];
  assign soft_reset_2 = soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
module tb_router_sync;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int checks = 0;
  int failures = 0;

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Reset state
    tick();
    write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
    #1;
    chk("rst_write_enb", write_enb, 3'b000);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
    chk("rst_vld_empty", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);
    empty_1 = 1'b0;
    #1;
    chk("rst_vld_follow", {vld_out_2, vld_out_1, vld_out_0}, 3'b010);
    empty_1 = 1'b1; write_enb_reg = 1'b0; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Address 1 then write
    resetn = 1'b1; detect_add = 1'b1; data_in = 2'd1;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    #1;
    chk("addr1_write_enb", write_enb, 3'b010);
    full_1 = 1'b1;
    #1;
    chk("addr1_full1", fifo_full, 1'b1);
    full_1 = 1'b0; full_0 = 1'b1;
    #1;
    chk("addr1_full0_only", fifo_full, 1'b0);
    full_0 = 1'b0;

    // Same edge as detect_add still uses the old address
    detect_add = 1'b1; data_in = 2'd2;
    #1;
    chk("old_addr_same_cycle", write_enb, 3'b010);
    tick();
    detect_add = 1'b0;
    #1;
    chk("addr2_write_enb", write_enb, 3'b100);
    full_2 = 1'b1;
    #1;
    chk("addr2_full2", fifo_full, 1'b1);
    full_2 = 1'b0;

    detect_add = 1'b1; data_in = 2'd0;
    tick();
    detect_add = 1'b0;
    #1;
    chk("addr0_write_enb", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    #1;
    chk("no_req_write_enb", write_enb, 3'b000);

    // Invalid address 3
    detect_add = 1'b1; data_in = 2'd3;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
    #1;
    chk("addr3_write_enb", write_enb, 3'b000);
    chk("addr3_fifo_full", fifo_full, 1'b0);
    write_enb_reg = 1'b0; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Timeout on channel 0, then repeat pulse with stall held
    empty_0 = 1'b0; read_enb_0 = 1'b0;
    #1;
    chk("vld0_up", vld_out_0, 1'b1);
    repeat (29) tick();
    chk("to_edge29", soft_reset_0, 1'b0);
    tick();
    chk("to_edge30", soft_reset_0, 1'b1);
    tick();
    chk("to_edge31", soft_reset_0, 1'b0);
    repeat (28) tick();
    chk("to_edge59", soft_reset_0, 1'b0);
    tick();
    chk("to_edge60", soft_reset_0, 1'b1);
    tick();
    chk("to_edge61", soft_reset_0, 1'b0);
    empty_0 = 1'b1;
    tick();

    // Read rescue on the deadline edge
    empty_0 = 1'b0;
    repeat (29) tick();
    read_enb_0 = 1'b1;
    tick();
    chk("rescue_no_pulse", soft_reset_0, 1'b0);
    read_enb_0 = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      chk("rescue_restart", soft_reset_0, 1'b0);
    end
    tick();
    chk("rescue_refire", soft_reset_0, 1'b1);
    empty_0 = 1'b1;
    tick();

    // FIFO emptied mid-count clears the counter
    empty_0 = 1'b0;
    repeat (15) tick();
    empty_0 = 1'b1;
    tick();
    empty_0 = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      chk("empty_clear", soft_reset_0, 1'b0);
    end
    tick();
    chk("empty_clear_fire", soft_reset_0, 1'b1);
    empty_0 = 1'b1;
    tick();

    // Simultaneous channels 0 and 2; channel 1 read every cycle
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0; read_enb_1 = 1'b1;
    repeat (29) tick();
    chk("sim_edge29", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
    tick();
    chk("sim_edge30", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b101);
    tick();
    chk("sim_edge31", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1; read_enb_1 = 1'b0;
    tick();

    // Reset mid-operation: addr=2, channel 2 mid-count
    detect_add = 1'b1; data_in = 2'd2;
    tick();
    detect_add = 1'b0;
    empty_2 = 1'b0;
    repeat (20) tick();
    resetn = 1'b0; write_enb_reg = 1'b1; full_2 = 1'b1;
    tick();
    chk("midrst_write_enb", write_enb, 3'b000);
    chk("midrst_fifo_full", fifo_full, 1'b0);
    chk("midrst_soft_reset", soft_reset_2, 1'b0);
    resetn = 1'b1; write_enb_reg = 1'b0; full_2 = 1'b0;
    for (int i = 0; i < 29; i++) begin
      tick();
      chk("midrst_no_early", soft_reset_2, 1'b0);
    end
    tick();
    chk("midrst_fire", soft_reset_2, 1'b1);
    empty_2 = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
